// File: rtl/pu_accum_addsub.sv
// pu_accum_addsub: adds b, optionally negated, to a and flags signed overflow.
module pu_accum_addsub #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  neg,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  overflow
);
    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    logic [DATA_WIDTH-1:0] op;
    logic                  neg_ovf;
    logic                  add_ovf;
    always_comb begin
        op       = neg ? (~b + 1'b1) : b;
        neg_ovf  = neg && (b == MOST_NEG);
        sum      = a + op;
        add_ovf  = (a[DATA_WIDTH-1] == op[DATA_WIDTH-1]) && (sum[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
        overflow = neg_ovf | add_ovf;
    end
endmodule

// File: rtl/pu_accum.sv
// pu_accum: bus accumulator unit; sums signed operands and drives the total on output-enable.
module pu_accum #(
    parameter int DATA_WIDTH = 32,
    parameter int ATTR_WIDTH = 4,
    parameter int SIGN       = 0,
    parameter int OVERFLOW   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signal_load,
    input  logic                  signal_init,
    input  logic                  signal_neg,
    input  logic                  signal_oe,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ATTR_WIDTH-1:0] attr_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ATTR_WIDTH-1:0] attr_out
);
    logic [DATA_WIDTH-1:0] acc_q, acc_d, data_out_q, data_out_d, sum;
    logic [ATTR_WIDTH-1:0] attr_out_q, attr_out_d;
    logic                  ovf_q, ovf_d, sum_ovf;

    // A new sum adds to zero, so init and accumulate share the same adder.
    pu_accum_addsub #(.DATA_WIDTH(DATA_WIDTH)) u_addsub (
        .a        (signal_init ? '0 : acc_q),
        .b        (data_in),
        .neg      (signal_neg ^ attr_in[SIGN]),
        .sum      (sum),
        .overflow (sum_ovf)
    );

    always_comb begin
        acc_d                = signal_load ? sum : acc_q;
        ovf_d                = signal_load ? ((ovf_q & ~signal_init) | attr_in[OVERFLOW] | sum_ovf) : ovf_q;
        data_out_d           = signal_oe ? acc_q : '0;
        attr_out_d           = '0;
        attr_out_d[SIGN]     = signal_oe & acc_q[DATA_WIDTH-1];
        attr_out_d[OVERFLOW] = signal_oe & ovf_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            data_out_q <= '0;
            attr_out_q <= '0;
        end else begin
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            data_out_q <= data_out_d;
            attr_out_q <= attr_out_d;
        end
    end

    assign data_out = data_out_q;
    assign attr_out = attr_out_q;
endmodule

// File: tb/tb_pu_accum.sv
// tb_pu_accum: directed checks of pu_accum at DATA_WIDTH=4.
module tb_pu_accum;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       signal_load = 1'b0, signal_init = 1'b0, signal_neg = 1'b0, signal_oe = 1'b0;
    logic [3:0] data_in = '0, attr_in = '0;
    logic [3:0] data_out, attr_out;
    int         checks = 0, errors = 0;

    pu_accum #(.DATA_WIDTH(4), .ATTR_WIDTH(4), .SIGN(0), .OVERFLOW(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .signal_load (signal_load),
        .signal_init (signal_init),
        .signal_neg  (signal_neg),
        .signal_oe   (signal_oe),
        .data_in     (data_in),
        .attr_in     (attr_in),
        .data_out    (data_out),
        .attr_out    (attr_out)
    );

    always #5 clk = ~clk;

    task automatic step(input logic l, input logic i, input logic n, input logic o,
                        input logic [3:0] d, input logic [3:0] a);
        signal_load = l; signal_init = i; signal_neg = n; signal_oe = o;
        data_in = d; attr_in = a;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(1, 1, 0, 1, 4'd5, 4'b0010);
        step(1, 0, 0, 1, 4'd5, 4'b0010);
        checks++;
        if (data_out !== 4'd0 || attr_out !== 4'd0) begin
            errors++;
            $display("FAIL reset_hold data_out=%h attr_out=%h exp 0 0", data_out, attr_out);
        end
        rst = 1'b1;
        step(0, 0, 0, 1, 4'd0, 4'd0);
        checks++;
        if (data_out !== 4'd0 || attr_out !== 4'd0) begin
            errors++;
            $display("FAIL reset_release data_out=%h attr_out=%h exp 0 0", data_out, attr_out);
        end
    endtask

    task automatic test_plain_sum();
        step(1, 1, 0, 0, 4'd2, 4'd0);
        step(1, 0, 0, 0, 4'd3, 4'd0);
        step(0, 0, 0, 1, 4'd0, 4'd0);
        checks++;
        if (data_out !== 4'd5 || attr_out !== 4'd0) begin
            errors++;
            $display("FAIL plain_sum data_out=%h attr_out=%h exp 5 0", data_out, attr_out);
        end
        step(0, 0, 0, 0, 4'd0, 4'd0);
        checks++;
        if (data_out !== 4'd0 || attr_out !== 4'd0) begin
            errors++;
            $display("FAIL oe_drop data_out=%h attr_out=%h exp 0 0", data_out, attr_out);
        end
    endtask

    task automatic test_negation();
        step(1, 1, 0, 0, 4'd2, 4'd0);
        step(1, 0, 1, 0, 4'd5, 4'd0);
        step(0, 0, 0, 1, 4'd0, 4'd0);
        checks++;
        if (data_out !== 4'hd || attr_out !== 4'b0001) begin
            errors++;
            $display("FAIL neg_signal data_out=%h attr_out=%h exp d 1", data_out, attr_out);
        end
        step(1, 1, 0, 0, 4'd2, 4'd0);
        step(1, 0, 0, 0, 4'd5, 4'b0001);
        step(0, 0, 0, 1, 4'd0, 4'd0);
        checks++;
        if (data_out !== 4'hd || attr_out !== 4'b0001) begin
            errors++;
            $display("FAIL neg_attr data_out=%h attr_out=%h exp d 1", data_out, attr_out);
        end
        step(1, 1, 1, 0, 4'd3, 4'b0001);
        step(0, 0, 0, 1, 4'd0, 4'd0);
        checks++;
        if (data_out !== 4'd3 || attr_out !== 4'b0000) begin
            errors++;
            $display("FAIL neg_cancel data_out=%h attr_out=%h exp 3 0", data_out, attr_out);
        end
    endtask

    task automatic test_overflow();
        step(1, 1, 0, 0, 4'd7, 4'd0);
        step(1, 0, 0, 0, 4'd1, 4'd0);
        step(0, 0, 0, 1, 4'd0, 4'd0);
        checks++;
        if (data_out !== 4'h8 || attr_out !== 4'b0011) begin
            errors++;
            $display("FAIL add_ovf data_out=%h attr_out=%h exp 8 3", data_out, attr_out);
        end
        step(1, 0, 0, 0, 4'd1, 4'd0);
        step(0, 0, 0, 1, 4'd0, 4'd0);
        checks++;
        if (data_out !== 4'h9 || attr_out !== 4'b0011) begin
            errors++;
            $display("FAIL ovf_sticky data_out=%h attr_out=%h exp 9 3", data_out, attr_out);
        end
        step(1, 1, 0, 0, 4'd1, 4'd0);
        step(0, 0, 0, 1, 4'd0, 4'd0);
        checks++;
        if (data_out !== 4'd1 || attr_out !== 4'b0000) begin
            errors++;
            $display("FAIL ovf_clear data_out=%h attr_out=%h exp 1 0", data_out, attr_out);
        end
        step(1, 1, 1, 0, 4'h8, 4'd0);
        step(0, 0, 0, 1, 4'd0, 4'd0);
        checks++;
        if (data_out !== 4'h8 || attr_out !== 4'b0011) begin
            errors++;
            $display("FAIL neg_min_ovf data_out=%h attr_out=%h exp 8 3", data_out, attr_out);
        end
        step(1, 1, 0, 0, 4'd2, 4'b0010);
        step(0, 0, 0, 1, 4'd0, 4'd0);
        checks++;
        if (data_out !== 4'd2 || attr_out !== 4'b0010) begin
            errors++;
            $display("FAIL attr_in_ovf data_out=%h attr_out=%h exp 2 2", data_out, attr_out);
        end
    endtask

    task automatic test_hold_timing();
        step(1, 1, 0, 0, 4'd2, 4'd0);
        step(1, 0, 0, 0, 4'd3, 4'd0);
        for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 4'hf, 4'b0011);
        step(0, 0, 0, 1, 4'd0, 4'd0);
        checks++;
        if (data_out !== 4'd5) begin
            errors++;
            $display("FAIL hold data_out=%h exp 5", data_out);
        end
        step(1, 0, 0, 1, 4'd1, 4'd0);
        checks++;
        if (data_out !== 4'd5) begin
            errors++;
            $display("FAIL oe_with_load data_out=%h exp 5", data_out);
        end
        step(0, 0, 0, 1, 4'd0, 4'd0);
        checks++;
        if (data_out !== 4'd6) begin
            errors++;
            $display("FAIL after_load data_out=%h exp 6", data_out);
        end
    endtask

    task automatic test_back_to_back();
        step(1, 1, 0, 0, 4'd1, 4'd0);
        step(1, 0, 0, 0, 4'd2, 4'd0);
        step(1, 0, 0, 0, 4'd3, 4'd0);
        step(1, 0, 0, 0, 4'hf, 4'd0);
        step(0, 0, 0, 1, 4'd0, 4'd0);
        checks++;
        if (data_out !== 4'd5 || attr_out !== 4'd0) begin
            errors++;
            $display("FAIL back_to_back data_out=%h attr_out=%h exp 5 0", data_out, attr_out);
        end
    endtask

    task automatic test_mid_reset();
        step(1, 1, 0, 0, 4'd3, 4'd0);
        rst = 1'b0;
        step(0, 0, 0, 0, 4'd0, 4'd0);
        rst = 1'b1;
        step(1, 0, 0, 0, 4'd4, 4'd0);
        step(0, 0, 0, 1, 4'd0, 4'd0);
        checks++;
        if (data_out !== 4'd4 || attr_out !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset data_out=%h attr_out=%h exp 4 0", data_out, attr_out);
        end
    endtask

    initial begin
        test_reset();
        test_plain_sum();
        test_negation();
        test_overflow();
        test_hold_timing();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
